// File: rtl/pin_attempt_controller.sv
// Attempt/lockout/session policy controller between the keypad front end and the PIN checker.
// Gates digit submits, counts consecutive failures, times lockouts and sessions, raises a sticky alarm.
//
// state   | meaning
// --------+-------------------------------------------------------------
// READY   | entry allowed; submits forwarded, verdict edges acted on
// LOCKOUT | too many failures; submits dropped until the timer expires
// SESSION | PIN approved; held open until the timer expires or logout
module pin_attempt_controller #(
    parameter int MAX_TRIES      = 3,
    parameter int LOCK_CYCLES    = 1000,
    parameter int SESSION_CYCLES = 500,
    parameter int ALARM_LOCKS    = 2,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_submit,
    input  logic             logout,
    input  logic             chk_correct,
    input  logic             chk_incorrect,
    output logic             chk_submit,
    output logic             chk_clear,
    output logic             locked,
    output logic             session,
    output logic [1:0]       fail_count,
    output logic [CNT_W-1:0] timer,
    output logic             alarm
);

    localparam logic [1:0] ST_READY   = 2'd0;
    localparam logic [1:0] ST_LOCKOUT = 2'd1;
    localparam logic [1:0] ST_SESSION = 2'd2;

    localparam logic [2:0]       MAX_T     = 3'(MAX_TRIES);
    localparam logic [1:0]       ALARM_T   = 2'(ALARM_LOCKS);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SESS_LOAD = CNT_W'(SESSION_CYCLES - 1);

    logic [1:0] state;
    logic       cor_q;
    logic       inc_q;
    logic [1:0] lock_count;
    logic       cor_rise;
    logic       inc_rise;
    logic [2:0] fail_inc;
    logic [1:0] lock_next;

    assign cor_rise  = chk_correct & ~cor_q;
    assign inc_rise  = chk_incorrect & ~inc_q;
    assign fail_inc  = {1'b0, fail_count} + 3'd1;
    assign lock_next = (lock_count == 2'd3) ? 2'd3 : lock_count + 2'd1;

    assign locked  = (state == ST_LOCKOUT);
    assign session = (state == ST_SESSION);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_READY;
            chk_submit <= 1'b0;
            chk_clear  <= 1'b1;
            fail_count <= 2'd0;
            timer      <= '0;
            alarm      <= 1'b0;
            lock_count <= 2'd0;
            cor_q      <= 1'b0;
            inc_q      <= 1'b0;
        end else begin
            cor_q      <= chk_correct;
            inc_q      <= chk_incorrect;
            chk_submit <= 1'b0;
            chk_clear  <= 1'b0;
            case (state)
                ST_READY: begin
                    chk_submit <= key_submit;
                    // a simultaneous correct edge is discarded: incorrect wins
                    if (inc_rise) begin
                        if (fail_inc == MAX_T) begin
                            state      <= ST_LOCKOUT;
                            timer      <= LOCK_LOAD;
                            fail_count <= 2'd0;
                            chk_clear  <= 1'b1;
                            lock_count <= lock_next;
                            if (lock_next >= ALARM_T) begin
                                alarm <= 1'b1;
                            end
                        end else begin
                            fail_count <= fail_inc[1:0];
                        end
                    end else if (cor_rise) begin
                        state      <= ST_SESSION;
                        timer      <= SESS_LOAD;
                        fail_count <= 2'd0;
                    end
                end
                ST_LOCKOUT: begin
                    if (timer == '0) begin
                        state     <= ST_READY;
                        chk_clear <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_SESSION: begin
                    if (logout || timer == '0) begin
                        state     <= ST_READY;
                        timer     <= '0;
                        chk_clear <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= ST_READY;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pin_attempt_controller.sv
// Bench for pin_attempt_controller: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_pin_attempt_controller;

    localparam int MAX_TRIES      = 3;
    localparam int LOCK_CYCLES    = 1000;
    localparam int SESSION_CYCLES = 500;
    localparam int ALARM_LOCKS    = 2;
    localparam int CNT_W          = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             key_submit = 1'b0;
    logic             logout = 1'b0;
    logic             chk_correct = 1'b0;
    logic             chk_incorrect = 1'b0;
    logic             chk_submit;
    logic             chk_clear;
    logic             locked;
    logic             session;
    logic [1:0]       fail_count;
    logic [CNT_W-1:0] timer;
    logic             alarm;

    int n_checks = 0;
    int n_fails  = 0;

    pin_attempt_controller #(
        .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES), .SESSION_CYCLES(SESSION_CYCLES),
        .ALARM_LOCKS(ALARM_LOCKS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .key_submit(key_submit), .logout(logout),
        .chk_correct(chk_correct), .chk_incorrect(chk_incorrect),
        .chk_submit(chk_submit), .chk_clear(chk_clear), .locked(locked), .session(session),
        .fail_count(fail_count), .timer(timer), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: lockout/session are windows of absolute edge numbers,
    // and the timer is simply the distance to the last edge of the window.
    longint k         = 0;
    longint lock_last = -1;
    longint sess_last = -1;
    bit     m_valid   = 0;
    int     m_fails   = 0;
    int     m_locks   = 0;
    bit     m_alarm   = 0;
    bit     e_submit  = 0;
    bit     e_clear   = 0;
    bit     prev_cor  = 0;
    bit     prev_inc  = 0;

    always @(posedge clk) begin
        bit ir, cr;
        k++;
        if (!reset) begin
            m_valid   = 1;
            lock_last = -1;
            sess_last = -1;
            m_fails   = 0;
            m_locks   = 0;
            m_alarm   = 0;
            e_submit  = 0;
            e_clear   = 1;
            prev_cor  = 0;
            prev_inc  = 0;
        end else if (m_valid) begin
            ir = chk_incorrect && !prev_inc;
            cr = chk_correct && !prev_cor;
            prev_cor = chk_correct;
            prev_inc = chk_incorrect;
            e_submit = 0;
            e_clear  = 0;
            if (k - 1 <= lock_last) begin
                if (k - 1 == lock_last) e_clear = 1;
            end else if (k - 1 <= sess_last) begin
                if (logout || k - 1 == sess_last) begin
                    sess_last = k - 1;
                    e_clear   = 1;
                end
            end else begin
                e_submit = key_submit;
                if (ir) begin
                    m_fails++;
                    if (m_fails == MAX_TRIES) begin
                        lock_last = k + LOCK_CYCLES - 1;
                        m_fails   = 0;
                        e_clear   = 1;
                        if (m_locks < 3) m_locks++;
                        if (m_locks >= ALARM_LOCKS) m_alarm = 1;
                    end
                end else if (cr) begin
                    sess_last = k + SESSION_CYCLES - 1;
                    m_fails   = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        longint e_timer;
        if (m_valid) begin
            e_timer = (k <= lock_last) ? lock_last - k : (k <= sess_last) ? sess_last - k : 0;
            check("model chk_submit", chk_submit, e_submit);
            check("model chk_clear", chk_clear, e_clear);
            check("model locked", locked, k <= lock_last);
            check("model session", session, k <= sess_last);
            check("model fail_count", fail_count, m_fails);
            check("model timer", timer, e_timer);
            check("model alarm", alarm, m_alarm);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic inc_pulse();
        chk_incorrect = 1'b1;
        cyc(1);
        chk_incorrect = 1'b0;
    endtask

    // Counts cycles the given level stays high from the current observation on.
    task automatic measure_high(input bit is_lock, input string name, input int expected);
        int n;
        n = 1;
        for (int i = 0; i < 2 * LOCK_CYCLES; i++) begin
            cyc(1);
            if (!(is_lock ? locked : session)) break;
            n++;
        end
        check(name, n, expected);
        check({name, " exit clear"}, chk_clear, 1);
    endtask

    task automatic wait_timer(input int value);
        int i;
        for (i = 0; i < 2 * LOCK_CYCLES; i++) begin
            if (timer == CNT_W'(value)) break;
            cyc(1);
        end
        check("wait timer bound", (i < 2 * LOCK_CYCLES) ? 1 : 0, 1);
    endtask

    initial begin
        // reset and submit forwarding
        reset = 1'b0;
        cyc(2);
        check("reset chk_clear", chk_clear, 1);
        check("reset timer", timer, 0);
        check("reset locked", locked, 0);
        reset = 1'b1;
        cyc(1);
        check("clear after release", chk_clear, 0);
        key_submit = 1'b1;
        cyc(1);
        key_submit = 1'b0;
        check("submit forwarded", chk_submit, 1);
        cyc(1);
        check("submit one cycle", chk_submit, 0);

        // three failures -> lockout
        inc_pulse(); check("fail 1", fail_count, 1); cyc(1);
        inc_pulse(); check("fail 2", fail_count, 2); cyc(1);
        chk_incorrect = 1'b1;
        cyc(1);
        chk_incorrect = 1'b0;
        check("lock entry locked", locked, 1);
        check("lock entry timer", timer, 999);
        check("lock entry fails", fail_count, 0);
        check("lock entry clear", chk_clear, 1);
        key_submit = 1'b1;
        cyc(1);
        key_submit = 1'b0;
        check("submit dropped in lock", chk_submit, 0);
        measure_high(1, "lock length", LOCK_CYCLES - 1);
        check("alarm after 1 lock", alarm, 0);

        // two failures then correct -> session, full length
        inc_pulse(); cyc(1);
        inc_pulse(); cyc(1);
        chk_correct = 1'b1;
        cyc(1);
        chk_correct = 1'b0;
        check("session entry", session, 1);
        check("session timer", timer, 499);
        check("session fails", fail_count, 0);
        measure_high(0, "session length", SESSION_CYCLES);

        // session ended by logout at timer=300
        chk_correct = 1'b1;
        cyc(1);
        chk_correct = 1'b0;
        wait_timer(300);
        logout = 1'b1;
        cyc(1);
        logout = 1'b0;
        check("logout session", session, 0);
        check("logout clear", chk_clear, 1);
        check("logout timer", timer, 0);

        // simultaneous edges count as incorrect; held level counts once
        chk_correct = 1'b1;
        chk_incorrect = 1'b1;
        cyc(1);
        chk_correct = 1'b0;
        check("both edges fail", fail_count, 1);
        check("both edges no session", session, 0);
        cyc(10);
        chk_incorrect = 1'b0;
        check("held level once", fail_count, 1);
        cyc(1);
        inc_pulse(); check("fail after hold", fail_count, 2); cyc(1);
        inc_pulse();
        check("second lock", locked, 1);
        check("alarm on second lock", alarm, 1);
        measure_high(1, "lock2 length", LOCK_CYCLES);
        chk_correct = 1'b1;
        cyc(1);
        chk_correct = 1'b0;
        check("session after alarm", session, 1);
        check("alarm sticky", alarm, 1);
        cyc(20);
        logout = 1'b1;
        cyc(1);
        logout = 1'b0;

        // reset mid-lockout and mid-session
        inc_pulse(); cyc(1);
        inc_pulse(); cyc(1);
        inc_pulse();
        wait_timer(500);
        reset = 1'b0;
        cyc(1);
        check("rst lock locked", locked, 0);
        check("rst lock timer", timer, 0);
        check("rst lock alarm", alarm, 0);
        check("rst lock clear", chk_clear, 1);
        check("rst lock fails", fail_count, 0);
        reset = 1'b1;
        cyc(1);
        chk_correct = 1'b1;
        cyc(1);
        chk_correct = 1'b0;
        cyc(100);
        reset = 1'b0;
        cyc(1);
        check("rst sess session", session, 0);
        check("rst sess timer", timer, 0);
        check("rst sess clear", chk_clear, 1);
        reset = 1'b1;
        cyc(1);

        // randomized soak against the model
        for (int i = 0; i < 20000; i++) begin
            key_submit = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) chk_incorrect = ~chk_incorrect;
            if ($urandom_range(0, 9) == 0) chk_correct = ~chk_correct;
            logout = ($urandom_range(0, 199) == 0);
            reset  = !($urandom_range(0, 2999) == 0);
            cyc(1);
        end
        reset = 1'b1;
        key_submit = 1'b0;
        logout = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
